subservient_dbg_loader: RTL and testbench
=========================================

# subservient_dbg_loader

Byte-stream-to-Wishbone debug initiator that drives the subservient core's debug port. It accepts command frames on an 8-bit valid/ready stream (typically fed by a UART receiver) and performs 32-bit Wishbone reads and writes on the debug bus. Each transaction returns a response on an 8-bit output stream. It owns `o_debug_mode`, which holds the CPU instruction fetch off while program memory is loaded, and releases it on command.

## Interface
Parameters:
- `DEBUG_AT_RESET`, default 1: reset value of `o_debug_mode`.
- `TIMEOUT`, default 255: bus-cycle timeout, in clocks. Used only with the macro; must be ≥1.

Ports:
- `i_clk`  in  1  clock; all logic is rising-edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_rx_data`  in  8  command stream byte.
- `i_rx_valid`  in  1  command byte valid.
- `o_rx_ready`  out  1  loader accepts a byte; a byte transfers when valid & ready.
- `o_tx_data`  out  8  response byte.
- `o_tx_valid`  out  1  response byte valid.
- `i_tx_ready`  in  1  response consumer ready.
- `o_debug_mode`  out  1  to core `i_debug_mode`.
- `o_wb_dbg_adr`  out  32  Wishbone address.
- `o_wb_dbg_dat`  out  32  Wishbone write data.
- `o_wb_dbg_sel`  out  4  byte select; constant 4'hF.
- `o_wb_dbg_we`  out  1  write enable.
- `o_wb_dbg_stb`  out  1  strobe, which is also the cycle.
- `i_wb_dbg_rdt`  in  32  read data.
- `i_wb_dbg_ack`  in  1  acknowledge.

## Operation
- Frame format: CMD byte, then ADDR as 4 bytes little-endian, then, for writes only, DATA as 4 bytes little-endian.
- Commands:
  - 0x57 'W': write DATA to ADDR. Response is one byte, 0x4B 'K'.
  - 0x52 'R': read ADDR. Response is 4 bytes of read data, little-endian, LSB first.
  - 0x47 'G': clear `o_debug_mode`. No address, no response.
  - 0x44 'D': set `o_debug_mode`. No address, no response.
  - Any other CMD byte is consumed and discarded; the loader stays in IDLE.
- State machine: IDLE, ADDR, DATA, BUS, RESP. A 2-bit byte counter indexes ADDR, DATA and RESP.
  - IDLE → ADDR on 'W' or 'R'.
  - ADDR → DATA after 4 bytes if the command is 'W'. ADDR → BUS after 4 bytes if the command is 'R'.
  - DATA → BUS after 4 bytes.
  - BUS → RESP on ack (or timeout).
  - RESP → IDLE after the last response byte is accepted.
- `o_rx_ready` = 1 in IDLE, ADDR and DATA. It is 0 in BUS and RESP.
- ADDR and DATA bytes shift into `o_wb_dbg_adr` / `o_wb_dbg_dat`. Byte n fills bits [8n+7:8n].
- `o_debug_mode` is unaffected by W/R. The bus is driven regardless of debug mode.

## Timing
- Reset values:
  - `o_wb_dbg_stb`, `o_wb_dbg_we`, `o_rx_ready`, `o_tx_valid` = 0.
  - `o_wb_dbg_adr`, `o_wb_dbg_dat`, `o_tx_data` = 0.
  - `o_debug_mode` = `DEBUG_AT_RESET`.
  - State = IDLE. `o_rx_ready` rises on the first clock after reset deasserts.
- Bus start: `o_wb_dbg_stb` rises in the cycle after the last ADDR/DATA byte is accepted. `o_wb_dbg_we` is valid with stb. adr/dat are stable while stb is high.
- Ack handling: stb is held until the cycle in which `i_wb_dbg_ack` = 1. stb is low in the following cycle. `i_wb_dbg_rdt` is captured in the ack cycle.
- An ack arriving while stb = 0 is ignored.
- RESP: `o_tx_valid` rises in the cycle after ack. Bytes advance on tx_valid & tx_ready; data is stable while valid & !ready.
- Minimum write frame: 9 accepted bytes, +1 cycle to stb, + slave latency, +1 cycle to tx_valid.
- 'G'/'D' take effect in the cycle after the CMD byte is accepted.
- Reset asserted mid-frame or mid-bus-cycle: immediately drops stb and tx_valid and returns to IDLE. Partial frames are discarded.

## Configuration
- `SUBSERVIENT_LOADER_TIMEOUT_EN` defined: an 8+-bit counter runs while stb = 1.
  - When it reaches `TIMEOUT` without ack, stb drops and RESP is entered.
  - Write response is 0x45 'E'. Read response is 0xFFFFFFFF.
  - An ack in the same cycle as expiry counts as success.
- Macro undefined: there is no counter, the loader waits indefinitely for ack, and 'E' is never produced.

## Test plan
- Write: stream 57 00 00 00 00 EF BE AD DE, slave acks after 2 cycles → one stb pulse with adr = 0x00000000, dat = 0xDEADBEEF, we = 1, sel = F; response 0x4B.
- Read: stream 52 04 00 00 20, slave returns 0x12345678 → we = 0, adr = 0x20000004; response bytes 78 56 34 12 in order.
- Backpressure: hold `i_tx_ready` = 0 for 5 cycles during a read response → `o_tx_data` stable, no byte lost, `o_rx_ready` = 0 throughout.
- Mode control: after reset `o_debug_mode` = 1; send 0x47 → 0 next cycle; send 0x13 → ignored; send 0x44 → 1.
- Reset mid-operation: assert `i_rst` while stb = 1 → stb = 0 asynchronously; a new 'W' frame then completes normally.
- Timeout (macro on, `TIMEOUT` = 4): write frame with no ack → stb high exactly 4 cycles, then response 0x45; read with no ack → FF FF FF FF.

Source files
------------

// File: rtl/subservient_dbg_loader.sv
// subservient_dbg_loader: byte-stream command frames to Wishbone debug cycles.
// Optional bus timeout enabled by defining SUBSERVIENT_LOADER_TIMEOUT_EN.
`timescale 1ns/1ps
module subservient_dbg_loader #(
   parameter bit DEBUG_AT_RESET = 1'b1,
   parameter int TIMEOUT        = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic        o_rx_ready,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_debug_mode,
   output logic [31:0] o_wb_dbg_adr,
   output logic [31:0] o_wb_dbg_dat,
   output logic [3:0]  o_wb_dbg_sel,
   output logic        o_wb_dbg_we,
   output logic        o_wb_dbg_stb,
   input  logic [31:0] i_wb_dbg_rdt,
   input  logic        i_wb_dbg_ack
);

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] CMD_G = 8'h47;
   localparam logic [7:0] CMD_D = 8'h44;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  cnt;
   logic [31:0] rsp;
   logic        rx_acc;
   logic        tx_acc;
   logic        ack;
   logic        expire;
   logic        last;
   logic        is_rw;

   assign rx_acc       = i_rx_valid & o_rx_ready;
   assign tx_acc       = o_tx_valid & i_tx_ready;
   assign o_wb_dbg_stb = (state == S_BUS);
   assign o_tx_valid   = (state == S_RESP);
   assign o_tx_data    = rsp[7:0];
   assign o_wb_dbg_sel = 4'hF;
   assign ack          = o_wb_dbg_stb & i_wb_dbg_ack;
   assign is_rw        = (i_rx_data == CMD_W) | (i_rx_data == CMD_R);
   // a write answers with one byte, a read with four
   assign last         = o_wb_dbg_we | (cnt == 2'd3);

`ifdef SUBSERVIENT_LOADER_TIMEOUT_EN
   localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [TW-1:0] tcnt;

   // count cycles spent with stb high
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         tcnt <= '0;
      else if (state == S_BUS)
         tcnt <= tcnt + 1'b1;
      else
         tcnt <= '0;
   end

   assign expire = (state == S_BUS) & (tcnt == TW'(TIMEOUT - 1));
`else
   // no counter: a legal TIMEOUT is never below 1, so this never expires
   assign expire = (TIMEOUT < 1);
`endif

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:
            if (rx_acc && is_rw)
               state_nxt = S_ADDR;
         S_ADDR:
            if (rx_acc && cnt == 2'd3)
               state_nxt = o_wb_dbg_we ? S_DATA : S_BUS;
         S_DATA:
            if (rx_acc && cnt == 2'd3)
               state_nxt = S_BUS;
         S_BUS:
            if (ack || expire)
               state_nxt = S_RESP;
         S_RESP:
            if (tx_acc && last)
               state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // frame capture, response shifting and debug-mode control
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_rx_ready   <= 1'b0;
         o_wb_dbg_we  <= 1'b0;
         o_wb_dbg_adr <= '0;
         o_wb_dbg_dat <= '0;
         o_debug_mode <= DEBUG_AT_RESET;
         cnt          <= '0;
         rsp          <= '0;
      end else begin
         o_rx_ready <= (state_nxt == S_IDLE) | (state_nxt == S_ADDR) |
                       (state_nxt == S_DATA);
         if (state_nxt != state)
            cnt <= '0;
         else if ((rx_acc && state != S_IDLE) || tx_acc)
            cnt <= cnt + 2'd1;
         if (state == S_IDLE && rx_acc) begin
            if (is_rw)
               o_wb_dbg_we <= (i_rx_data == CMD_W);
            if (i_rx_data == CMD_G)
               o_debug_mode <= 1'b0;
            if (i_rx_data == CMD_D)
               o_debug_mode <= 1'b1;
         end
         if (state == S_ADDR && rx_acc)
            o_wb_dbg_adr[{cnt, 3'b000} +: 8] <= i_rx_data;
         if (state == S_DATA && rx_acc)
            o_wb_dbg_dat[{cnt, 3'b000} +: 8] <= i_rx_data;
         if (state == S_BUS) begin
            if (ack)
               rsp <= o_wb_dbg_we ? 32'h0000_004B : i_wb_dbg_rdt;
            else if (expire)
               rsp <= o_wb_dbg_we ? 32'h0000_0045 : 32'hFFFF_FFFF;
         end else if (tx_acc) begin
            rsp <= {8'h00, rsp[31:8]};
         end
      end
   end

endmodule

// File: tb/tb_subservient_dbg_loader.sv
// Bench for subservient_dbg_loader: directed test-plan steps plus random
// read/write traffic against a memory model kept in the bench.
`timescale 1ns/1ps
module tb_subservient_dbg_loader;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_valid = 1'b0;
   logic        o_rx_ready;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready = 1'b0;
   logic        o_debug_mode;
   logic [31:0] o_wb_dbg_adr;
   logic [31:0] o_wb_dbg_dat;
   logic [3:0]  o_wb_dbg_sel;
   logic        o_wb_dbg_we;
   logic        o_wb_dbg_stb;
   logic [31:0] i_wb_dbg_rdt = 32'h0;
   logic        i_wb_dbg_ack = 1'b0;

   always #5 i_clk = ~i_clk;

   subservient_dbg_loader #(
      .DEBUG_AT_RESET (1'b1),
      .TIMEOUT        (4)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid),
      .o_rx_ready   (o_rx_ready),
      .o_tx_data    (o_tx_data),
      .o_tx_valid   (o_tx_valid),
      .i_tx_ready   (i_tx_ready),
      .o_debug_mode (o_debug_mode),
      .o_wb_dbg_adr (o_wb_dbg_adr),
      .o_wb_dbg_dat (o_wb_dbg_dat),
      .o_wb_dbg_sel (o_wb_dbg_sel),
      .o_wb_dbg_we  (o_wb_dbg_we),
      .o_wb_dbg_stb (o_wb_dbg_stb),
      .i_wb_dbg_rdt (i_wb_dbg_rdt),
      .i_wb_dbg_ack (i_wb_dbg_ack)
   );

   int vectors = 0;
   int miscompares = 0;

   // slave memory and the bench's independent expectation of it
   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   // slave control and observations
   int          lat_cfg = 0;
   int          cd = 0;
   bit          no_ack = 1'b0;
   bit          spur = 1'b0;
   bit          s_prev = 1'b0;
   int          s_len = 0;
   int          s_unstable = 0;
   logic [31:0] s_adr = 32'h0;
   logic [31:0] s_dat = 32'h0;
   logic        s_we = 1'b0;
   logic [3:0]  s_sel = 4'h0;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return ~a ^ 32'h5A5A_5A5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Wishbone slave: acks after lat_cfg extra cycles, may ack spuriously
   always @(negedge i_clk) begin
      i_wb_dbg_ack = 1'b0;
      if (o_wb_dbg_stb) begin
         if (!s_prev) begin
            cd    = lat_cfg;
            s_len = 0;
            s_adr = o_wb_dbg_adr;
            s_dat = o_wb_dbg_dat;
            s_we  = o_wb_dbg_we;
            s_sel = o_wb_dbg_sel;
         end else if (o_wb_dbg_adr !== s_adr || o_wb_dbg_dat !== s_dat ||
                      o_wb_dbg_we !== s_we) begin
            s_unstable++;
         end
         s_len++;
         if (!no_ack && cd == 0) begin
            i_wb_dbg_ack = 1'b1;
            if (o_wb_dbg_we) begin
               mem[o_wb_dbg_adr] = o_wb_dbg_dat;
               i_wb_dbg_rdt = $urandom;
            end else begin
               i_wb_dbg_rdt = mem.exists(o_wb_dbg_adr) ?
                              mem[o_wb_dbg_adr] : dflt(o_wb_dbg_adr);
            end
         end else if (cd > 0) begin
            cd--;
         end
      end else if (spur) begin
         i_wb_dbg_ack = 1'($urandom % 2);
      end
      s_prev = o_wb_dbg_stb;
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      if ($urandom % 4 == 0) begin
         i_rx_valid = 1'b0;
         @(negedge i_clk);
      end
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      while (!o_rx_ready && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      chk("rx_ready_wait", 32'(o_rx_ready), 32'd1);
      @(negedge i_clk);
      i_rx_valid = 1'b0;
      i_rx_data  = 8'($urandom);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                             input logic [31:0] d);
      send_byte(cmd);
      for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8]);
      if (cmd == 8'h57)
         for (int i = 0; i < 4; i++) send_byte(d[i*8 +: 8]);
      chk("stb_start", 32'(o_wb_dbg_stb), 32'd1);
      chk("we_with_stb", 32'(o_wb_dbg_we), 32'(cmd == 8'h57));
   endtask

   // collect n response bytes LSB first with random (or forced) backpressure
   task automatic recv(input int n, input bit bp, output logic [31:0] w);
      int   got = 0;
      int   to = 0;
      int   hold = 0;
      bit   stall = 1'b0;
      logic [7:0] prevd = 8'h00;
      w = 32'h0;
      while (got < n && to < 200) begin
         if (bp && got == 1 && o_tx_valid && hold < 5) begin
            i_tx_ready = 1'b0;
            hold++;
         end else begin
            i_tx_ready = ($urandom % 3 != 0);
         end
         if (stall) chk("tx_stable", 32'(o_tx_data), 32'(prevd));
         if (o_tx_valid) chk("rx_ready_low", 32'(o_rx_ready), 32'd0);
         if (o_tx_valid && i_tx_ready) begin
            w[got*8 +: 8] = o_tx_data;
            got++;
         end
         stall = o_tx_valid && !i_tx_ready;
         prevd = o_tx_data;
         @(negedge i_clk);
         to++;
      end
      i_tx_ready = 1'b0;
      chk("resp_bytes", 32'(got), 32'(n));
      chk("tx_done", 32'(o_tx_valid), 32'd0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input int lat);
      logic [31:0] w;
      lat_cfg = lat;
      send_frame(8'h57, a, d);
      recv(1, 1'b0, w);
      chk("wr_resp", w, 32'h4B);
      chk("wr_stb_len", 32'(s_len), 32'(lat + 1));
      chk("wr_adr", s_adr, a);
      chk("wr_dat", s_dat, d);
      chk("wr_sel", 32'(s_sel), 32'hF);
      chk("wr_we", 32'(s_we), 32'd1);
      ref_mem[a] = d;
   endtask

   task automatic do_read(input logic [31:0] a, input int lat, input bit bp);
      logic [31:0] w;
      logic [31:0] exp;
      exp = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
      lat_cfg = lat;
      send_frame(8'h52, a, 32'h0);
      recv(4, bp, w);
      chk("rd_data", w, exp);
      chk("rd_stb_len", 32'(s_len), 32'(lat + 1));
      chk("rd_adr", s_adr, a);
      chk("rd_we", 32'(s_we), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic [31:0] bases [4];

      // reset values
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("rst_stb", 32'(o_wb_dbg_stb), 32'd0);
      chk("rst_we", 32'(o_wb_dbg_we), 32'd0);
      chk("rst_rx_ready", 32'(o_rx_ready), 32'd0);
      chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
      chk("rst_adr", o_wb_dbg_adr, 32'h0);
      chk("rst_dat", o_wb_dbg_dat, 32'h0);
      chk("rst_tx_data", 32'(o_tx_data), 32'h0);
      chk("rst_dbg", 32'(o_debug_mode), 32'd1);
      i_rst = 1'b0;
      chk("rx_ready_at_release", 32'(o_rx_ready), 32'd0);
      @(negedge i_clk);
      chk("rx_ready_first_clk", 32'(o_rx_ready), 32'd1);

      // debug-mode control, unknown command ignored
      send_byte(8'h47);
      chk("dbg_after_G", 32'(o_debug_mode), 32'd0);
      send_byte(8'h13);
      chk("dbg_after_13", 32'(o_debug_mode), 32'd0);
      chk("idle_after_13", 32'(o_rx_ready), 32'd1);

      // directed write, slave acks on the second stb cycle
      do_write(32'h0000_0000, 32'hDEAD_BEEF, 1);
      chk("dbg_after_W", 32'(o_debug_mode), 32'd0);
      send_byte(8'h44);
      chk("dbg_after_D", 32'(o_debug_mode), 32'd1);

      // directed read with 5-cycle backpressure
      mem[32'h2000_0004]     = 32'h1234_5678;
      ref_mem[32'h2000_0004] = 32'h1234_5678;
      do_read(32'h2000_0004, 2, 1'b1);
      do_read(32'h0000_0000, 0, 1'b0);

      // reset while a bus cycle is pending
      no_ack = 1'b1;
      lat_cfg = 0;
      send_frame(8'h57, 32'h0000_0100, 32'hCAFE_F00D);
      repeat (2) @(negedge i_clk);
      chk("stb_before_rst", 32'(o_wb_dbg_stb), 32'd1);
      i_rst = 1'b1;
      #1;
      chk("stb_async_rst", 32'(o_wb_dbg_stb), 32'd0);
      chk("tx_valid_async_rst", 32'(o_tx_valid), 32'd0);
      chk("rx_ready_async_rst", 32'(o_rx_ready), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      chk("adr_after_rst", o_wb_dbg_adr, 32'h0);
      @(negedge i_clk);
      chk("rx_ready_after_rst", 32'(o_rx_ready), 32'd1);
      chk("dbg_after_rst", 32'(o_debug_mode), 32'd1);
      no_ack = 1'b0;
      do_write(32'h0000_0100, 32'h0BAD_CAFE, 0);
      do_read(32'h0000_0100, 1, 1'b0);

`ifdef SUBSERVIENT_LOADER_TIMEOUT_EN
      // no ack: stb held exactly TIMEOUT cycles, error responses
      no_ack = 1'b1;
      send_frame(8'h57, 32'h0000_0200, 32'h1111_2222);
      recv(1, 1'b0, w);
      chk("tmo_wr_resp", w, 32'h45);
      chk("tmo_wr_len", 32'(s_len), 32'd4);
      send_frame(8'h52, 32'h0000_0200, 32'h0);
      recv(4, 1'b0, w);
      chk("tmo_rd_resp", w, 32'hFFFF_FFFF);
      chk("tmo_rd_len", 32'(s_len), 32'd4);
      no_ack = 1'b0;
`endif

      // random traffic over a few addresses, spurious acks while idle
      spur = 1'b1;
      for (int i = 0; i < 4; i++) bases[i] = $urandom;
      for (int i = 0; i < 24; i++) begin
         if ($urandom % 2 == 0)
            do_write(bases[$urandom % 4], $urandom, int'($urandom % 4));
         else
            do_read(bases[$urandom % 4], int'($urandom % 4),
                    1'($urandom % 4 == 0));
         if ($urandom % 5 == 0) begin
            send_byte(8'($urandom % 2 == 0 ? 8'h47 : 8'h44));
         end
      end
      spur = 1'b0;

      chk("adr_dat_stable", 32'(s_unstable), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
